// File: rtl/loop_filter.sv
// Proportional-integral loop filter for a bang-bang ADPLL: saturating integral accumulator plus proportional kick.
// Latency: 1 cycle from inputs to registered outputs; the integral path into Fractional_Frequency lags one extra cycle.
// Backpressure: none; updates every clock with no handshake.
module loop_filter (
    input  logic              clk,
    input  logic              reset,
    input  logic              early,
    input  logic [1:0]        sel,
    input  logic signed [4:0] plusInt,
    input  logic signed [4:0] minusInt,
    input  logic signed [4:0] plusProp,
    input  logic signed [4:0] plusPropDiff,
    input  logic signed [4:0] minusProp,
    input  logic signed [4:0] minusPropDiff,
    output logic signed [4:0] INT_OUT,
    output logic signed [4:0] Fractional_Frequency,
    output logic              overflow,
    output logic              underflow,
    output logic              OverflowP,
    output logic              UnderflowP
);

    localparam logic signed [4:0] SAT_MAX = 5'sb01111;
    localparam logic signed [4:0] SAT_MIN = 5'sb10000;
    localparam logic signed [5:0] SUM_MAX = 6'sd15;
    localparam logic signed [5:0] SUM_MIN = -6'sd16;

    logic signed [4:0] int_q, int_d;
    logic signed [4:0] frac_q, frac_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              ovfp_q, ovfp_d;
    logic              unfp_q, unfp_d;

    logic signed [4:0] int_step;
    logic signed [4:0] prop_step;
    logic signed [5:0] int_sum;
    logic signed [5:0] frac_sum;

    always_comb begin
        int_step  = early ? plusInt : minusInt;
        prop_step = 5'sd0;
        if (!sel[1]) begin
            if (early) prop_step = sel[0] ? plusPropDiff : plusProp;
            else       prop_step = sel[0] ? minusPropDiff : minusProp;
        end

        // Sign-extend to 6 bits so the sum of two 5-bit values cannot wrap.
        int_sum  = {int_q[4], int_q} + {int_step[4], int_step};
        frac_sum = {int_q[4], int_q} + {prop_step[4], prop_step};

        int_d = int_sum[4:0];
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (int_sum > SUM_MAX) begin
            int_d = SAT_MAX;
            ovf_d = 1'b1;
        end else if (int_sum < SUM_MIN) begin
            int_d = SAT_MIN;
            unf_d = 1'b1;
        end

        frac_d = frac_sum[4:0];
        ovfp_d = 1'b0;
        unfp_d = 1'b0;
        if (frac_sum > SUM_MAX) begin
            frac_d = SAT_MAX;
            ovfp_d = 1'b1;
        end else if (frac_sum < SUM_MIN) begin
            frac_d = SAT_MIN;
            unfp_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            int_q  <= 5'sd0;
            frac_q <= 5'sd0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            ovfp_q <= 1'b0;
            unfp_q <= 1'b0;
        end else begin
            int_q  <= int_d;
            frac_q <= frac_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            ovfp_q <= ovfp_d;
            unfp_q <= unfp_d;
        end
    end

    assign INT_OUT              = int_q;
    assign Fractional_Frequency = frac_q;
    assign overflow             = ovf_q;
    assign underflow            = unf_q;
    assign OverflowP            = ovfp_q;
    assign UnderflowP           = unfp_q;

endmodule

// File: tb/tb_loop_filter.sv
// Testbench for loop_filter: directed table, hand-written saturation/reset sequences, randomized run against an integer model.
module tb_loop_filter;

    logic              clk = 1'b0;
    logic              reset;
    logic              early;
    logic [1:0]        sel;
    logic signed [4:0] plusInt, minusInt, plusProp, plusPropDiff, minusProp, minusPropDiff;
    logic signed [4:0] INT_OUT, Fractional_Frequency;
    logic              overflow, underflow, OverflowP, UnderflowP;

    int checks = 0;
    int errors = 0;

    // integer reference model state
    int m_int, m_frac, m_ovf, m_unf, m_ovfp, m_unfp;

    always #5 clk = ~clk;

    loop_filter dut (
        .clk                 (clk),
        .reset               (reset),
        .early               (early),
        .sel                 (sel),
        .plusInt             (plusInt),
        .minusInt            (minusInt),
        .plusProp            (plusProp),
        .plusPropDiff        (plusPropDiff),
        .minusProp           (minusProp),
        .minusPropDiff       (minusPropDiff),
        .INT_OUT             (INT_OUT),
        .Fractional_Frequency(Fractional_Frequency),
        .overflow            (overflow),
        .underflow           (underflow),
        .OverflowP           (OverflowP),
        .UnderflowP          (UnderflowP)
    );

    typedef struct {
        int         pre;
        logic       e;
        logic [1:0] s;
        int pi, mi, pp, ppd, mp, mpd;
        int ei, eo, eu, ef, eop, eup;
    } vec_t;

    vec_t tbl [12];

    function automatic int clamp(input int v);
        if (v > 15) return 15;
        if (v < -16) return -16;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ei, input int eo, input int eu,
                           input int ef, input int eop, input int eup);
        int v_int, v_frac;
        v_int  = INT_OUT;
        v_frac = Fractional_Frequency;
        chk({tag, ".INT_OUT"}, v_int, ei);
        chk({tag, ".overflow"}, int'(overflow), eo);
        chk({tag, ".underflow"}, int'(underflow), eu);
        chk({tag, ".Fractional_Frequency"}, v_frac, ef);
        chk({tag, ".OverflowP"}, int'(OverflowP), eop);
        chk({tag, ".UnderflowP"}, int'(UnderflowP), eup);
    endtask

    task automatic drive(input logic e, input logic [1:0] s, input int pi, input int mi,
                         input int pp, input int ppd, input int mp, input int mpd);
        early         = e;
        sel           = s;
        plusInt       = 5'(pi);
        minusInt      = 5'(mi);
        plusProp      = 5'(pp);
        plusPropDiff  = 5'(ppd);
        minusProp     = 5'(mp);
        minusPropDiff = 5'(mpd);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges; called 1 time unit after a rising edge.
    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    // Model step from the current inputs, applied at the coming edge.
    task automatic model_step();
        int i_v, p_v, s_v, f_v;
        i_v = early ? int'(plusInt) : int'(minusInt);
        if (sel[1])      p_v = 0;
        else if (early)  p_v = sel[0] ? int'(plusPropDiff) : int'(plusProp);
        else             p_v = sel[0] ? int'(minusPropDiff) : int'(minusProp);
        s_v    = m_int + i_v;
        f_v    = m_int + p_v;
        m_ovf  = (s_v > 15) ? 1 : 0;
        m_unf  = (s_v < -16) ? 1 : 0;
        m_ovfp = (f_v > 15) ? 1 : 0;
        m_unfp = (f_v < -16) ? 1 : 0;
        m_int  = clamp(s_v);
        m_frac = clamp(f_v);
    endtask

    task automatic model_reset();
        m_int = 0; m_frac = 0; m_ovf = 0; m_unf = 0; m_ovfp = 0; m_unfp = 0;
    endtask

    initial begin
        //          pre  e  sel    pi  mi   pp  ppd  mp   mpd   ei  eo eu  ef  eop eup
        tbl[0]  = '{  0, 1, 2'b00,  0,  0,  -6,  13, -10, -13,   0, 0, 0,  -6, 0, 0};
        tbl[1]  = '{  0, 1, 2'b01,  0,  0,  -6,  13, -10, -13,   0, 0, 0,  13, 0, 0};
        tbl[2]  = '{  0, 0, 2'b00,  0,  0,  -6,  13, -10, -13,   0, 0, 0, -10, 0, 0};
        tbl[3]  = '{  0, 0, 2'b01,  0,  0,  -6,  13, -10, -13,   0, 0, 0, -13, 0, 0};
        tbl[4]  = '{  7, 1, 2'b01,  0,  0,  -6,  13, -10, -13,   7, 0, 0,  15, 1, 0};
        tbl[5]  = '{-14, 0, 2'b01,  0,  0,  -6,  13, -10, -13, -14, 0, 0, -16, 0, 1};
        tbl[6]  = '{  5, 1, 2'b10,  0,  0,  15,  15, -16, -16,   5, 0, 0,   5, 0, 0};
        tbl[7]  = '{  5, 0, 2'b11,  0,  0,  15,  15, -16, -16,   5, 0, 0,   5, 0, 0};
        tbl[8]  = '{ 10, 1, 2'b00,  9,  0,   0,   7,   3,   3,  15, 1, 0,  10, 0, 0};
        tbl[9]  = '{-10, 0, 2'b00,  0, -8,   5,   5,   0,   5, -16, 0, 1, -10, 0, 0};
        tbl[10] = '{ 15, 0, 2'b10,  3,-16,  15,  15,  15,  15,  -1, 0, 0,  15, 0, 0};
        tbl[11] = '{-16, 1, 2'b00, 15,  0,  15,  -3,  -3,  -3,  -1, 0, 0,  -1, 0, 0};

        // Reset held low with arbitrary inputs, across rising edges.
        reset = 1'b0;
        drive(1'b1, 2'b01, 9, -5, 11, 12, -7, -9);
        #12;
        chk_all("reset_hold", 0, 0, 0, 0, 0, 0);
        drive(1'b1, 2'b10, 7, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        chk("reset_release.INT_OUT", int'(INT_OUT), 7);

        // Directed table: load INT_OUT to pre, then apply one vector.
        for (int k = 0; k < 12; k++) begin
            pulse_reset();
            drive(tbl[k].pre >= 0, 2'b10, tbl[k].pre, tbl[k].pre, 0, 0, 0, 0);
            tick();
            chk($sformatf("tbl%0d.load", k), int'(INT_OUT), tbl[k].pre);
            drive(tbl[k].e, tbl[k].s, tbl[k].pi, tbl[k].mi, tbl[k].pp, tbl[k].ppd, tbl[k].mp, tbl[k].mpd);
            tick();
            chk_all($sformatf("tbl%0d", k), tbl[k].ei, tbl[k].eo, tbl[k].eu, tbl[k].ef, tbl[k].eop, tbl[k].eup);
        end

        // Integral saturation high; Fractional_Frequency follows pre-update INT_OUT.
        pulse_reset();
        drive(1'b1, 2'b10, 7, 0, 0, 0, 0, 0);
        tick(); chk_all("sat_hi1", 7, 0, 0, 0, 0, 0);
        tick(); chk_all("sat_hi2", 14, 0, 0, 7, 0, 0);
        tick(); chk_all("sat_hi3", 15, 1, 0, 14, 0, 0);
        tick(); chk_all("sat_hi4", 15, 1, 0, 15, 0, 0);

        // Asynchronous reset mid-operation, held across an edge, then restart.
        reset = 1'b0;
        #2;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0);
        tick();
        chk_all("async_rst_hold", 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        chk_all("restart", 7, 0, 0, 0, 0, 0);

        // Integral saturation low, then flag clears.
        pulse_reset();
        drive(1'b0, 2'b10, 0, -7, 0, 0, 0, 0);
        tick(); chk_all("sat_lo1", -7, 0, 0, 0, 0, 0);
        tick(); chk_all("sat_lo2", -14, 0, 0, -7, 0, 0);
        tick(); chk_all("sat_lo3", -16, 0, 1, -14, 0, 0);
        drive(1'b1, 2'b10, 7, -7, 0, 0, 0, 0);
        tick(); chk_all("sat_lo_clr", -9, 0, 0, -16, 0, 0);

        // Randomized run against the model, with occasional async reset pulses.
        pulse_reset();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b0;
                #2;
                model_reset();
                chk_all($sformatf("rnd_rst%0d", n), 0, 0, 0, 0, 0, 0);
                reset = 1'b1;
            end
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  $signed(5'($urandom_range(0, 31))), $signed(5'($urandom_range(0, 31))),
                  $signed(5'($urandom_range(0, 31))), $signed(5'($urandom_range(0, 31))),
                  $signed(5'($urandom_range(0, 31))), $signed(5'($urandom_range(0, 31))));
            model_step();
            tick();
            chk_all($sformatf("rnd%0d", n), m_int, m_ovf, m_unf, m_frac, m_ovfp, m_unfp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
